// File: rtl/aurora_cmd_pkg.sv
// Shared types and helpers for the Aurora command burst generator.
package aurora_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_COLLECT     = 3'd1,
    ST_DROP        = 3'd2,
    ST_WAIT_CREDIT = 3'd3,
    ST_ISSUE_ADDR  = 3'd4,
    ST_ISSUE_DATA  = 3'd5
  } cmd_burst_state_t;

  // Position of the read flag inside an address beat.
  function automatic int unsigned rdflag_bit(input int unsigned data_width);
    return data_width - 1;
  endfunction

  // Index width for a buffer of the given depth (at least one bit).
  function automatic int unsigned buf_idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/aurora_cmd_burst_gen_buffer.sv
// Write-burst staging RAM: synchronous write, combinational read, no reset.
module cmd_burst_buffer
  import aurora_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  localparam int unsigned IDX_WIDTH = $clog2(MAX_BURST + 1)
) (
  input  logic                  clk,
  input  logic                  wr_en_i,
  input  logic [IDX_WIDTH-1:0]  wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [IDX_WIDTH-1:0]  rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_c
);

  localparam int unsigned AW    = buf_idx_width(MAX_BURST);
  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[AW'(wr_idx_i)] <= wr_data_i;
    end
  end

  assign rd_data_c = mem_q[AW'(rd_idx_i)];

endmodule

// File: rtl/aurora_cmd_burst_gen.sv
// Splits Aurora command packets into an address channel (with beat count)
// and a data channel; reads are gated by an outstanding-read credit count.
module aurora_cmd_burst_gen
  import aurora_cmd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned MAX_READS  = 4,
  localparam int unsigned LEN_WIDTH = $clog2(MAX_BURST + 1),
  localparam int unsigned RD_WIDTH  = $clog2(MAX_READS + 1)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_cmd_addr_tdata,
  output logic [LEN_WIDTH-1:0]  m_cmd_addr_tlen,
  output logic                  m_cmd_addr_tvalid,
  input  logic                  m_cmd_addr_tready,
  output logic [DATA_WIDTH-1:0] m_cmd_data_tdata,
  output logic                  m_cmd_data_tvalid,
  input  logic                  m_cmd_data_tready,
  output logic                  m_cmd_data_tlast,
  input  logic                  rd_done_i,
  output logic [RD_WIDTH-1:0]   rd_outstanding_o,
  output logic                  err_overlen_o
);

  localparam int unsigned RD_FLAG = rdflag_bit(DATA_WIDTH);
  localparam logic [LEN_WIDTH-1:0] BURST_MAX = LEN_WIDTH'(MAX_BURST);
  localparam logic [RD_WIDTH-1:0]  READS_MAX = RD_WIDTH'(MAX_READS);

  cmd_burst_state_t      state_q, state_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  ptr_q, ptr_d;
  logic [RD_WIDTH-1:0]   rd_out_q, rd_out_d;
  logic                  err_q, err_d;

  logic in_hs;
  logic addr_hs;
  logic data_hs;
  logic buf_we;
  logic rd_inc;
  logic rd_dec;

  // Channel controls decode straight from the registered state.
  assign s_axis_tready     = (state_q == ST_IDLE) || (state_q == ST_COLLECT) ||
                             (state_q == ST_DROP);
  assign m_cmd_addr_tvalid = (state_q == ST_ISSUE_ADDR);
  assign m_cmd_data_tvalid = (state_q == ST_ISSUE_DATA);
  assign m_cmd_data_tlast  = (ptr_q == (len_q - LEN_WIDTH'(1)));
  assign m_cmd_addr_tdata  = addr_q;
  assign m_cmd_addr_tlen   = len_q;
  assign rd_outstanding_o  = rd_out_q;
  assign err_overlen_o     = err_q;

  assign in_hs   = s_axis_tvalid && s_axis_tready;
  assign addr_hs = m_cmd_addr_tvalid && m_cmd_addr_tready;
  assign data_hs = m_cmd_data_tvalid && m_cmd_data_tready;

  cmd_burst_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) u_buffer (
    .clk       (aclk),
    .wr_en_i   (buf_we),
    .wr_idx_i  (cnt_q),
    .wr_data_i (s_axis_tdata),
    .rd_idx_i  (ptr_q),
    .rd_data_c (m_cmd_data_tdata)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    err_d    = 1'b0;
    rd_out_d = rd_out_q;
    buf_we   = 1'b0;
    rd_inc   = 1'b0;
    rd_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_hs) begin
          addr_d = s_axis_tdata;
          if (s_axis_tlast) begin
            addr_d[RD_FLAG] = 1'b1;
            len_d           = '0;
            state_d         = (rd_out_q < READS_MAX) ? ST_ISSUE_ADDR : ST_WAIT_CREDIT;
          end else begin
            addr_d[RD_FLAG] = 1'b0;
            cnt_d           = '0;
            state_d         = ST_COLLECT;
          end
        end
      end

      ST_COLLECT: begin
        if (in_hs) begin
          if (cnt_q < BURST_MAX) begin
            buf_we = 1'b1;
            cnt_d  = cnt_q + LEN_WIDTH'(1);
            if (s_axis_tlast) begin
              len_d   = cnt_q + LEN_WIDTH'(1);
              state_d = ST_ISSUE_ADDR;
            end
          end else begin
            err_d = 1'b1;
            if (s_axis_tlast) begin
              len_d   = cnt_q;
              state_d = ST_ISSUE_ADDR;
            end else begin
              state_d = ST_DROP;
            end
          end
        end
      end

      // Buffer is full: swallow the rest of the packet.
      ST_DROP: begin
        if (in_hs) begin
          err_d = 1'b1;
          if (s_axis_tlast) begin
            len_d   = BURST_MAX;
            state_d = ST_ISSUE_ADDR;
          end
        end
      end

      ST_WAIT_CREDIT: begin
        if (rd_out_q < READS_MAX) begin
          state_d = ST_ISSUE_ADDR;
        end
      end

      ST_ISSUE_ADDR: begin
        if (addr_hs) begin
          if (addr_q[RD_FLAG]) begin
            state_d = ST_IDLE;
          end else begin
            ptr_d   = '0;
            state_d = ST_ISSUE_DATA;
          end
        end
      end

      ST_ISSUE_DATA: begin
        if (data_hs) begin
          if (m_cmd_data_tlast) begin
            state_d = ST_IDLE;
          end else begin
            ptr_d = ptr_q + LEN_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Issue and drain in the same cycle cancel; drain at zero is ignored.
    rd_inc = addr_hs && addr_q[RD_FLAG];
    rd_dec = rd_done_i && (rd_out_q != '0);
    if (rd_inc && !rd_dec) begin
      rd_out_d = rd_out_q + RD_WIDTH'(1);
    end else if (!rd_inc && rd_dec) begin
      rd_out_d = rd_out_q - RD_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      rd_out_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      rd_out_q <= rd_out_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/aurora_cmd_burst_gen.md
# aurora_cmd_burst_gen

Converts inbound Aurora command packets (one header beat plus optional write-data beats) into a decoupled address channel and data channel for the register/bus master. It generalises single-word command splitting to parametrised widths and multi-beat write bursts. It buffers each write burst so the address beat can carry a beat count. It also gates reads on a credit counter so the read-response path can never deadlock. It sits between the Aurora RX command stream and the bus-master state machine.

## Interface
- `DATA_WIDTH`, 32: width of every beat; must be ≥16; bit `DATA_WIDTH-1` of the address beat is the read flag.
- `MAX_BURST`, 16: maximum write-data beats per packet; must be ≥1.
- `MAX_READS`, 4: maximum outstanding reads; must be ≥1.
- `LEN_WIDTH` (localparam): `$clog2(MAX_BURST+1)`.
- `RD_WIDTH` (localparam): `$clog2(MAX_READS+1)`.
- `aclk`  in  1  sole clock.
- `aresetn`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  DATA_WIDTH  command beat.
- `s_axis_tvalid` / `s_axis_tready` / `s_axis_tlast`  in/out/in  1  inbound handshake; `tlast` marks the end of the packet.
- `m_cmd_addr_tdata`  out  DATA_WIDTH  address beat, with the read flag forced.
- `m_cmd_addr_tlen`  out  LEN_WIDTH  number of data beats that follow (0 for a read).
- `m_cmd_addr_tvalid` / `m_cmd_addr_tready`  out/in  1  address handshake.
- `m_cmd_data_tdata`  out  DATA_WIDTH  write data.
- `m_cmd_data_tvalid` / `m_cmd_data_tready` / `m_cmd_data_tlast`  out/in/out  1  data handshake.
- `rd_done_i`  in  1  one-cycle pulse: one read response has been drained.
- `rd_outstanding_o`  out  RD_WIDTH  current outstanding-read count.
- `err_overlen_o`  out  1  one-cycle pulse for each discarded excess data beat.

## Operation
- **States:** IDLE, COLLECT, DROP, WAIT_CREDIT, ISSUE_ADDR, ISSUE_DATA.
- **`s_axis_tready` value:** 1 in IDLE, COLLECT and DROP; 0 in all other states.
- **IDLE, header accepted:** store the header in the address register.
  - Header with `tlast` is a read: force the flag bit to 1 and set len=0. Go to ISSUE_ADDR if `rd_outstanding_o < MAX_READS`, else WAIT_CREDIT.
  - Header without `tlast` is a write: force the flag bit to 0, clear the count, go to COLLECT.
- **COLLECT:**
  - Each accepted beat with count < MAX_BURST is written to the buffer at index count, then count increments.
  - A beat arriving with count == MAX_BURST is discarded and pulses `err_overlen_o`. If that beat lacks `tlast`, go to DROP.
  - A beat with `tlast`, kept or discarded, sets len=count (post-increment) and goes to ISSUE_ADDR.
- **DROP:** discard every beat and pulse `err_overlen_o` for each. On `tlast`, go to ISSUE_ADDR with len=MAX_BURST.
- **WAIT_CREDIT:** re-evaluate the credit every cycle against the registered count. Go to ISSUE_ADDR the cycle after the count drops below MAX_READS.
- **ISSUE_ADDR:** `m_cmd_addr_tvalid`=1, with data and len held stable until `tready`.
  - On the handshake of a read: go to IDLE and increment the outstanding count.
  - On the handshake of a write: go to ISSUE_DATA with read pointer 0.
- **ISSUE_DATA:** `m_cmd_data_tvalid`=1, presenting `buf[ptr]`. `tlast` = (ptr == len-1). The pointer advances on each handshake; the handshake with `tlast` returns to IDLE.
- **Outstanding counter:**
  - +1 on a read-address handshake; −1 on `rd_done_i`.
  - Both in the same cycle: unchanged.
  - `rd_done_i` while the count is 0 is ignored, with no underflow.
- **Reset (asynchronous, any state, mid-packet included):**
  - State goes to IDLE; all tvalid outputs, `err_overlen_o`, the counters and `rd_outstanding_o` go to 0; `m_cmd_addr_tdata`/`tlen` go to 0.
  - Buffer contents are not reset.
  - After reset the remainder of an interrupted inbound packet is treated as a new packet; upstream is responsible for flushing it.

## Timing
- **Read:** header accepted in cycle N; `m_cmd_addr_tvalid` high in N+1 when credit is available.
- **Write of L ≤ MAX_BURST beats:** header accepted in N and last beat in N+L. `m_cmd_addr_tvalid` is high in N+L+1. The first data beat is valid in the cycle after the address handshake. Thereafter one beat per cycle while `tready` is held.
- **Back-to-back packets:** IDLE (`s_axis_tready`=1) the cycle after the final address or data handshake.
- **Stability:** all master outputs are registered or driven from registered state. tvalid never drops without a handshake, and tdata does not change while valid && !ready.
- **`err_overlen_o`:** asserted in the cycle after the discarded beat's handshake.

## Structure
- Package `aurora_cmd_pkg` holds:
  - the state enum `cmd_burst_state_t`;
  - the read-flag bit position as function `rdflag_bit(DATA_WIDTH)`.
- Sub-module `cmd_burst_buffer`: MAX_BURST×DATA_WIDTH distributed RAM with synchronous write and combinational read, indexed by the write count and read pointer.

## Test plan
- **Read:** header 0x0000_1234 with `tlast` → address beat 0x8000_1234, len=0, valid at N+1; `rd_outstanding_o`=1.
- **Write, L=3:** header 0x8000_0010 then beats A, B, C (C with `tlast`) → address 0x0000_0010 with len=3, then A, B, C with `tlast` on C. Insert random `m_cmd_data_tready` stalls; data must stay stable while stalled.
- **Over-length write:** MAX_BURST+2 data beats → len=MAX_BURST, first MAX_BURST beats emitted, `err_overlen_o` pulsed exactly twice.
- **Credit exhaustion:** MAX_READS+1 reads with no `rd_done_i` → the last read stalls in WAIT_CREDIT with `s_axis_tready`=0. One `rd_done_i` releases it the following cycle; count returns to MAX_READS. A simultaneous `rd_done_i` and read-address handshake leaves the count unchanged.
- **Reset mid-burst:** `aresetn` low during ISSUE_DATA → all valids 0 immediately, count 0. A subsequent read behaves as in the read test.
